pack_alloc: RTL and testbench
=============================

Name: pack_alloc

Overview:
- Allocates 2-lane instruction pack slots on the dispatch side and drives the pack id and per-lane write enables into the per-pack instruction RAM.
- Tracks per-entry valid and done bits. An entry is addressed as rob_id = {pack_id, lane}.
- Completion reports from the two ALU issue ports mark entries done.
- The oldest pack is retired in order.

Parameters:
- PACKS, 16, number of pack slots; power of two.
- IDW, 4, pack id width, equal to log2(PACKS).

Ports:
- cpu_clk_i  in  1  core clock.
- cpu_rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  squash all in-flight packs.
- disp_valid_i  in  1  dispatch presents a pack.
- disp_ins0_valid_i  in  1  lane 0 of the presented pack is occupied.
- disp_ins1_valid_i  in  1  lane 1 of the presented pack is occupied.
- disp_ready_o  out  1  a pack can be accepted this cycle.
- pack_id_o  out  IDW  id assigned to the presented pack.
- ins0_wen_o  out  1  IRAM lane-0 write enable.
- ins1_wen_o  out  1  IRAM lane-1 write enable.
- cmpl0_valid_i  in  1  ALU0 completion report.
- cmpl0_rob_i  in  IDW+1  ROB id completed by ALU0.
- cmpl1_valid_i  in  1  ALU1 completion report.
- cmpl1_rob_i  in  IDW+1  ROB id completed by ALU1.
- head_done_o  out  1  oldest pack has completed.
- head_id_o  out  IDW  oldest pack id.
- head_lanes_o  out  2  valid lanes of the oldest pack.
- commit_i  in  1  retire the oldest pack.
- empty_o  out  1  no packs in flight.
- full_o  out  1  all PACKS slots are in use.
- occupancy_o  out  IDW+1  number of packs in flight.
- err_o  out  1  sticky protocol error flag.

Behaviour:
- State:
  - head and tail pointers, IDW+1 bits each; the MSB is the wrap bit.
  - valid[2*PACKS] and done[2*PACKS] bitmaps.
  - sticky err bit.
- Reset (async, cpu_rst_ni low) sets every state bit to 0. Resulting outputs:
  - disp_ready_o=1, empty_o=1, full_o=0, occupancy_o=0.
  - head_done_o=0, head_id_o=0, head_lanes_o=0, pack_id_o=0, err_o=0.
  - ins0_wen_o=ins1_wen_o=0.
- Status flags:
  - full_o when head and tail have equal index and differing wrap bits.
  - empty_o when head==tail.
  - occupancy_o = tail - head, modulo 2^(IDW+1).
- Dispatch:
  - disp_ready_o = !full_o && !flush_i.
  - pack_id_o = tail[IDW-1:0], combinational.
  - accept = disp_valid_i & disp_ready_o & (disp_ins0_valid_i | disp_ins1_valid_i).
  - ins0_wen_o = accept & disp_ins0_valid_i; ins1_wen_o = accept & disp_ins1_valid_i. Both are combinational, in the same cycle as the accept.
  - On accept at the next edge: tail increments; valid bits for that pack's lanes are set from the lane flags; both done bits are cleared.
  - A dispatch with no lanes valid is not accepted and does not change the tail.
- Completion:
  - When cmplN_valid_i is asserted, done[cmplN_rob_i] is set at the next edge.
  - Both ports may report in the same cycle, including the same id; the result is the idempotent OR.
  - A completion to an entry whose valid bit is 0 sets err and leaves done unchanged.
- Head status:
  - head_id_o = head[IDW-1:0].
  - head_lanes_o = valid bits of the head pack.
  - head_done_o = !empty_o, and every valid lane of the head pack has its done bit set.
  - Registered state only; no same-cycle bypass from the completion ports.
- Commit:
  - commit_i while head_done_o=1: clear the valid and done bits of the head pack; head increments.
  - commit_i while head_done_o=0: ignored, and err is set.
- Simultaneous events:
  - Dispatch and commit in the same cycle: both take effect. occupancy_o is unchanged.
  - While full, a same-cycle commit does not free a slot for that cycle; disp_ready_o stays 0.
- Wrap: pointers wrap modulo 2*PACKS. Ids 15 then 0 are consecutive.
- Flush:
  - flush_i has highest priority: dispatch, completion and commit in that cycle are discarded.
  - At the next edge: head=tail=0 and all valid and done bits are cleared.
  - err is not cleared by flush; only reset clears it.

Optional Feature:
- Macro: PACK_ALLOC_PERF_EN.
- When defined, adds two outputs:
  - perf_stall_o, 32 bits: counts cycles with disp_valid_i=1 and full_o=1. Saturates at 2^32-1.
  - perf_commit_o, 32 bits: counts committed packs. Wraps.
- Both counters reset to 0; flush does not clear them.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then dispatch one pack with both lanes valid -> pack_id_o=0, ins0_wen_o=ins1_wen_o=1 in that cycle; next cycle occupancy_o=1, head_lanes_o=2'b11, head_done_o=0.
- Dispatch a lane-0-only pack; complete ROB id 0 on cmpl1 -> head_done_o=1 one cycle later; commit_i -> empty_o=1, head_id_o=1.
- Dispatch 16 packs with no commits -> full_o=1, disp_ready_o=0; dispatch plus commit in the same cycle -> the dispatch is not accepted and occupancy_o=15 next cycle.
- Run 40 dispatch/complete/commit cycles -> pack_id_o sequence 15,0,1 across the wrap with no err_o.
- With 5 packs in flight, assert flush_i together with disp_valid_i and commit_i -> next cycle empty_o=1, pack_id_o=0, no write enables during the flush cycle.
- commit_i while head_done_o=0, and a completion to an invalid ROB id 7 -> err_o=1 and stays 1 through a flush; reset clears it.

Source files
------------

// File: rtl/pack_alloc.sv
// Two-lane pack slot allocator with per-entry valid/done tracking and in-order retire.
// Optional performance counters are enabled by defining PACK_ALLOC_PERF_EN.
module pack_alloc #(
    parameter int PACKS = 16,
    parameter int IDW   = 4
) (
    input  logic           cpu_clk_i,
    input  logic           cpu_rst_ni,
    input  logic           flush_i,
    input  logic           disp_valid_i,
    input  logic           disp_ins0_valid_i,
    input  logic           disp_ins1_valid_i,
    output logic           disp_ready_o,
    output logic [IDW-1:0] pack_id_o,
    output logic           ins0_wen_o,
    output logic           ins1_wen_o,
    input  logic           cmpl0_valid_i,
    input  logic [IDW:0]   cmpl0_rob_i,
    input  logic           cmpl1_valid_i,
    input  logic [IDW:0]   cmpl1_rob_i,
    output logic           head_done_o,
    output logic [IDW-1:0] head_id_o,
    output logic [1:0]     head_lanes_o,
    input  logic           commit_i,
    output logic           empty_o,
    output logic           full_o,
    output logic [IDW:0]   occupancy_o,
    output logic           err_o
`ifdef PACK_ALLOC_PERF_EN
   ,output logic [31:0]    perf_stall_o,
    output logic [31:0]    perf_commit_o
`endif
);

    logic [IDW:0]       r_head;
    logic [IDW:0]       r_tail;
    logic [2*PACKS-1:0] r_valid;
    logic [2*PACKS-1:0] r_done;
    logic               r_err;

    logic               w_empty;
    logic               w_full;
    logic               w_accept;
    logic               w_head_done;
    logic               w_commit;
    logic               w_err_set;
    logic [1:0]         w_head_lanes;
    logic [1:0]         w_head_dbits;
    logic [IDW:0]       w_head_e0;
    logic [IDW:0]       w_head_e1;
    logic [IDW:0]       w_tail_e0;
    logic [IDW:0]       w_tail_e1;
    logic [2*PACKS-1:0] w_valid_nxt;
    logic [2*PACKS-1:0] w_done_nxt;

    assign w_empty   = (r_head == r_tail);
    assign w_full    = (r_head[IDW-1:0] == r_tail[IDW-1:0]) && (r_head[IDW] != r_tail[IDW]);
    assign w_head_e0 = {r_head[IDW-1:0], 1'b0};
    assign w_head_e1 = {r_head[IDW-1:0], 1'b1};
    assign w_tail_e0 = {r_tail[IDW-1:0], 1'b0};
    assign w_tail_e1 = {r_tail[IDW-1:0], 1'b1};

    assign w_head_lanes = {r_valid[w_head_e1], r_valid[w_head_e0]};
    assign w_head_dbits = {r_done[w_head_e1], r_done[w_head_e0]};
    assign w_head_done  = !w_empty && ((w_head_dbits | ~w_head_lanes) == 2'b11);

    assign disp_ready_o = !w_full && !flush_i;
    assign w_accept     = disp_valid_i && disp_ready_o && (disp_ins0_valid_i || disp_ins1_valid_i);
    assign ins0_wen_o   = w_accept && disp_ins0_valid_i;
    assign ins1_wen_o   = w_accept && disp_ins1_valid_i;
    assign pack_id_o    = r_tail[IDW-1:0];

    assign w_commit  = commit_i && w_head_done && !flush_i;
    // Protocol errors: premature commit, or completion of an entry that was never dispatched.
    assign w_err_set = !flush_i &&
                       ((commit_i && !w_head_done) ||
                        (cmpl0_valid_i && !r_valid[cmpl0_rob_i]) ||
                        (cmpl1_valid_i && !r_valid[cmpl1_rob_i]));

    assign head_done_o  = w_head_done;
    assign head_id_o    = r_head[IDW-1:0];
    assign head_lanes_o = w_head_lanes;
    assign empty_o      = w_empty;
    assign full_o       = w_full;
    assign occupancy_o  = r_tail - r_head;
    assign err_o        = r_err;

    // The tail pack never aliases a live head pack, so the three updates do not collide.
    always_comb begin
        w_valid_nxt = r_valid;
        w_done_nxt  = r_done;
        if (cmpl0_valid_i && r_valid[cmpl0_rob_i]) w_done_nxt[cmpl0_rob_i] = 1'b1;
        if (cmpl1_valid_i && r_valid[cmpl1_rob_i]) w_done_nxt[cmpl1_rob_i] = 1'b1;
        if (w_accept) begin
            w_valid_nxt[w_tail_e0] = disp_ins0_valid_i;
            w_valid_nxt[w_tail_e1] = disp_ins1_valid_i;
            w_done_nxt[w_tail_e0]  = 1'b0;
            w_done_nxt[w_tail_e1]  = 1'b0;
        end
        if (w_commit) begin
            w_valid_nxt[w_head_e0] = 1'b0;
            w_valid_nxt[w_head_e1] = 1'b0;
            w_done_nxt[w_head_e0]  = 1'b0;
            w_done_nxt[w_head_e1]  = 1'b0;
        end
    end

    always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
        if (!cpu_rst_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            r_head  <= r_head + {{IDW{1'b0}}, w_commit};
            r_tail  <= r_tail + {{IDW{1'b0}}, w_accept};
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
            r_err   <= r_err | w_err_set;
        end
    end

`ifdef PACK_ALLOC_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_commit;

    always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
        if (!cpu_rst_ni) begin
            r_perf_stall  <= '0;
            r_perf_commit <= '0;
        end else begin
            if (disp_valid_i && w_full && (r_perf_stall != 32'hFFFF_FFFF))
                r_perf_stall <= r_perf_stall + 32'd1;
            if (w_commit)
                r_perf_commit <= r_perf_commit + 32'd1;
        end
    end

    assign perf_stall_o  = r_perf_stall;
    assign perf_commit_o = r_perf_commit;
`endif

endmodule

// File: tb/tb_pack_alloc.sv
// Directed self-checking bench for pack_alloc (default build, perf counters absent).
module tb_pack_alloc;

    logic       clk;
    logic       rstN;
    logic       flush;
    logic       dispValid;
    logic       ins0Valid;
    logic       ins1Valid;
    logic       dispReady;
    logic [3:0] packId;
    logic       ins0Wen;
    logic       ins1Wen;
    logic       cmpl0Valid;
    logic [4:0] cmpl0Rob;
    logic       cmpl1Valid;
    logic [4:0] cmpl1Rob;
    logic       headDone;
    logic [3:0] headId;
    logic [1:0] headLanes;
    logic       commit;
    logic       empty;
    logic       full;
    logic [4:0] occupancy;
    logic       err;

    int checkCount;
    int failCount;

    pack_alloc #(.PACKS(16), .IDW(4)) dut (
        .cpu_clk_i         (clk),
        .cpu_rst_ni        (rstN),
        .flush_i           (flush),
        .disp_valid_i      (dispValid),
        .disp_ins0_valid_i (ins0Valid),
        .disp_ins1_valid_i (ins1Valid),
        .disp_ready_o      (dispReady),
        .pack_id_o         (packId),
        .ins0_wen_o        (ins0Wen),
        .ins1_wen_o        (ins1Wen),
        .cmpl0_valid_i     (cmpl0Valid),
        .cmpl0_rob_i       (cmpl0Rob),
        .cmpl1_valid_i     (cmpl1Valid),
        .cmpl1_rob_i       (cmpl1Rob),
        .head_done_o       (headDone),
        .head_id_o         (headId),
        .head_lanes_o      (headLanes),
        .commit_i          (commit),
        .empty_o           (empty),
        .full_o            (full),
        .occupancy_o       (occupancy),
        .err_o             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Inputs change 1 ns after a rising edge so they are stable well before the next one.
    task automatic applyStimulus(input logic dv, input logic i0, input logic i1,
                                 input logic c0v, input logic [4:0] c0r,
                                 input logic c1v, input logic [4:0] c1r,
                                 input logic cm, input logic fl);
        dispValid  = dv;
        ins0Valid  = i0;
        ins1Valid  = i1;
        cmpl0Valid = c0v;
        cmpl0Rob   = c0r;
        cmpl1Valid = c1v;
        cmpl1Rob   = c1r;
        commit     = cm;
        flush      = fl;
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        rstN = 1'b0;
        idle();
        #11;

        checkOutput("rst_ready", dispReady, 1);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_occ", occupancy, 0);
        checkOutput("rst_hdone", headDone, 0);
        checkOutput("rst_hid", headId, 0);
        checkOutput("rst_hlanes", headLanes, 0);
        checkOutput("rst_packid", packId, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_wen", {ins0Wen, ins1Wen}, 0);
        rstN = 1'b1;
        step();

        // Two-lane pack 0, then lane-0-only pack 1.
        applyStimulus(1, 1, 1, 0, 5'd0, 0, 5'd0, 0, 0);
        checkOutput("d0_packid", packId, 0);
        checkOutput("d0_wen", {ins0Wen, ins1Wen}, 2'b11);
        step();
        idle();
        checkOutput("d0_occ", occupancy, 1);
        checkOutput("d0_hlanes", headLanes, 2'b11);
        checkOutput("d0_hdone", headDone, 0);
        applyStimulus(1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 0);
        checkOutput("d1_packid", packId, 1);
        checkOutput("d1_wen", {ins0Wen, ins1Wen}, 2'b10);
        step();
        applyStimulus(0, 0, 0, 1, 5'd1, 1, 5'd0, 0, 0);
        checkOutput("c0_nobypass", headDone, 0);
        step();
        idle();
        checkOutput("c0_hdone", headDone, 1);
        applyStimulus(0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 0);
        step();
        idle();
        checkOutput("cm0_hid", headId, 1);
        checkOutput("cm0_occ", occupancy, 1);
        checkOutput("cm0_hlanes", headLanes, 2'b01);
        checkOutput("cm0_hdone", headDone, 0);
        applyStimulus(0, 0, 0, 0, 5'd0, 1, 5'd2, 0, 0);
        step();
        idle();
        checkOutput("c1_hdone", headDone, 1);
        applyStimulus(0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 0);
        step();
        idle();
        checkOutput("cm1_empty", empty, 1);
        checkOutput("cm1_hid", headId, 2);

        // Fill all 16 slots starting at id 2.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1, 1, 1, 0, 5'd0, 0, 5'd0, 0, 0);
            step();
        end
        idle();
        checkOutput("fill_full", full, 1);
        checkOutput("fill_ready", dispReady, 0);
        checkOutput("fill_occ", occupancy, 16);
        checkOutput("fill_packid", packId, 2);
        applyStimulus(0, 0, 0, 1, 5'd4, 0, 5'd0, 0, 0);
        step();
        idle();
        checkOutput("half_hdone", headDone, 0);
        applyStimulus(0, 0, 0, 0, 5'd0, 1, 5'd5, 0, 0);
        step();
        idle();
        checkOutput("full_hdone", headDone, 1);
        applyStimulus(1, 1, 1, 0, 5'd0, 0, 5'd0, 1, 0);
        checkOutput("fullcm_ready", dispReady, 0);
        checkOutput("fullcm_wen", {ins0Wen, ins1Wen}, 0);
        step();
        idle();
        checkOutput("fullcm_occ", occupancy, 15);
        checkOutput("fullcm_full", full, 0);
        checkOutput("fullcm_hid", headId, 3);
        checkOutput("fullcm_err", err, 0);

        applyStimulus(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 1);
        step();
        idle();
        checkOutput("fl0_empty", empty, 1);

        // Pipelined run: dispatch pack k, complete pack k-1, commit pack k-2.
        for (int k = 0; k < 40; k++) begin
            logic [4:0] prevRob;
            prevRob = 5'(((k + 15) % 16) * 2);
            applyStimulus(1, 1, 1, k >= 1, prevRob, k >= 1, prevRob | 5'd1, k >= 2, 0);
            checkOutput($sformatf("wrap_packid%0d", k), packId, 32'(k % 16));
            if (k >= 2) checkOutput($sformatf("wrap_hdone%0d", k), headDone, 1);
            step();
        end
        idle();
        checkOutput("wrap_occ", occupancy, 2);
        checkOutput("wrap_hid", headId, 38 % 16);
        checkOutput("wrap_err", err, 0);

        // Grow to five packs, then flush while dispatching and committing.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 1, 1, 0, 5'd0, 0, 5'd0, 0, 0);
            step();
        end
        idle();
        checkOutput("pre_fl_occ", occupancy, 5);
        applyStimulus(1, 1, 1, 0, 5'd0, 0, 5'd0, 1, 1);
        checkOutput("fl_wen", {ins0Wen, ins1Wen}, 0);
        checkOutput("fl_ready", dispReady, 0);
        step();
        idle();
        checkOutput("fl_empty", empty, 1);
        checkOutput("fl_packid", packId, 0);
        checkOutput("fl_occ", occupancy, 0);
        checkOutput("fl_err", err, 0);

        // Error paths: premature commit, then completion to an invalid id.
        applyStimulus(0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 0);
        step();
        idle();
        checkOutput("errcm_err", err, 1);
        checkOutput("errcm_empty", empty, 1);
        applyStimulus(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 1);
        step();
        idle();
        checkOutput("errfl_err", err, 1);
        rstN = 1'b0;
        #2;
        checkOutput("errrst_err", err, 0);
        rstN = 1'b1;
        step();
        applyStimulus(1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 1, 5'd7, 1, 5'd1, 0, 0);
        step();
        idle();
        checkOutput("errcp_err", err, 1);
        checkOutput("errcp_hdone", headDone, 0);
        applyStimulus(0, 0, 0, 0, 5'd0, 1, 5'd0, 0, 0);
        step();
        idle();
        checkOutput("errcp_hdone2", headDone, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
